dft_seq_ctrl: RTL
=================

DFT_SEQ_CTRL -- requirements
Module: dft_seq_ctrl

Interface
REQ-001 Parameter N_W, default 12: width of the sample-count and index counters.
REQ-002 Parameter CH, default 2: number of input channels sequenced per run.
REQ-003 Parameter PIPE_LAT, default 3: datapath drain cycles after the last MAC of a channel, range 0-15.
REQ-004 Port clk, input, 1: clock; all logic on rising edge.
REQ-005 Port nrst, input, 1: reset, synchronous, active-low.
REQ-006 Port ce, input, 1: clock enable; while 0, state, counters and registered outputs hold, and single-cycle pulses deassert.
REQ-007 Port start, input, 1: run request, sampled only in IDLE.
REQ-008 Port sample_num, input, N_W: transform length N, latched on accepted start.
REQ-009 Port ch_mask, input, CH: channels to process, latched on accepted start.
REQ-010 Port inverse, input, 1: IDFT mode, latched on accepted start.
REQ-011 Port abort, input, 1: cancel the run.
REQ-012 Port load_to_cache, output, 1: cache write phase active.
REQ-013 Port clear, output, 1: accumulator clear strobe.
REQ-014 Port mac_en, output, 1: MAC enable for the current (n,k).
REQ-015 Port n_idx / k_idx, output, N_W each: sample index and bin index.
REQ-016 Port ch_sel, output, clog2(CH) (minimum 1): active channel.
REQ-017 Port inv_out, output, 1: latched inverse.
REQ-018 Port bin_done, output, 1: one-cycle pulse at the end of each bin.
REQ-019 Port busy / done / err, output, 1 each: run active / run-complete pulse / rejected-start pulse.
REQ-020 Port state, output, 3: encoding IDLE=0, LOAD=1, CLEAR=2, COMPUTE=3, DRAIN=4, DONE=5.

Function
REQ-021 All transitions and counter updates SHALL occur only on cycles with ce=1.
REQ-022 IDLE: on start=1 with sample_num>=2 and ch_mask!=0, latch the inputs, set ch_sel to the lowest set mask bit, and go to LOAD; otherwise, on start=1, pulse err for one cycle and remain in IDLE.
REQ-023 LOAD: load_to_cache=1; n_idx counts 0..N-1, one step per ce cycle; at n_idx=N-1 go to CLEAR.
REQ-024 CLEAR: clear=1 for exactly one ce cycle, n_idx and k_idx set to 0, then go to COMPUTE.
REQ-025 COMPUTE: mac_en=1; n_idx increments each cycle; at n_idx=N-1, bin_done pulses, n_idx wraps to 0, and k_idx increments.
REQ-026 COMPUTE at n_idx=N-1 and k_idx=N-1: bin_done pulses, and the state goes to DRAIN, or straight to the channel-advance step when PIPE_LAT=0.
REQ-027 DRAIN: mac_en=0; hold for PIPE_LAT ce cycles, then perform the channel-advance step.
REQ-028 Channel-advance step: if a higher mask bit remains set, ch_sel moves to the next set bit and the state goes to LOAD; otherwise the state goes to DONE.
REQ-029 DONE: done pulses for one cycle, then the state goes to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next ce cycle, with all strobes 0 and no done pulse; abort has priority over every other transition.
REQ-032 start=1 while busy=1 SHALL be ignored, with no err pulse.
REQ-033 Counters SHALL wrap at N-1, never at 2^N_W; sample_num=2^N_W-1 is legal.
REQ-034 Changes to sample_num, ch_mask or inverse mid-run SHALL have no effect until the next accepted start.

Reset
REQ-035 On nrst=0 at a clock edge, regardless of ce, the block SHALL enter IDLE.
REQ-036 Reset values: all outputs 0, n_idx=k_idx=0, ch_sel=0, inv_out=0, state=0.
REQ-037 Reset mid-run SHALL discard the latched parameters; no done pulse is issued.

Verification
REQ-038 N=4, ch_mask=01, PIPE_LAT=3, ce=1: LOAD 4 cycles, CLEAR 1, COMPUTE 16 with 4 bin_done pulses, DRAIN 3, then done; busy high for 25 cycles.
REQ-039 N=2, ch_mask=11: two full passes; ch_sel=0 during the first pass, 1 during the second; one done pulse total.
REQ-040 start with sample_num=1, or with ch_mask=0 -> single err pulse; state stays 0; busy stays 0.
REQ-041 abort at k_idx=2 in COMPUTE -> state=0 next cycle; no done; a new start is then accepted normally.
REQ-042 ce toggling 1,0 throughout the N=4 run -> identical output sequence stretched 2x; clear, bin_done and done each last one ce-qualified cycle.
REQ-043 nrst=0 asserted during DRAIN with ce=0 -> all outputs 0 after the next edge.

Source files
------------

// File: rtl/dft_seq_ctrl.sv
// Sequencer for a direct DFT engine: per enabled channel it loads N samples into
// the cache, clears the accumulator, walks every (n,k) MAC pair, then drains the datapath.
module dft_seq_ctrl #(
    parameter int N_W      = 12,
    parameter int CH       = 2,
    parameter int PIPE_LAT = 3,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            ce,
    input  logic            start,
    input  logic [N_W-1:0]  sample_num,
    input  logic [CH-1:0]   ch_mask,
    input  logic            inverse,
    input  logic            abort,
    output logic            load_to_cache,
    output logic            clear,
    output logic            mac_en,
    output logic [N_W-1:0]  n_idx,
    output logic [N_W-1:0]  k_idx,
    output logic [CH_W-1:0] ch_sel,
    output logic            inv_out,
    output logic            bin_done,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CLEAR   = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [3:0] DRAIN_LAST = (PIPE_LAT > 0) ? 4'(PIPE_LAT - 1) : 4'd0;

    state_t          st_q, st_d, st_adv;
    logic [N_W-1:0]  n_q, n_d, k_q, k_d, last_q;
    logic [CH_W-1:0] ch_q, ch_d, lo_ch, nx_ch, ch_adv;
    logic [CH-1:0]   mask_q;
    logic            inv_q, err_q;
    logic [3:0]      dr_q, dr_d;
    logic            nx_vld, accept, reject, n_wrap, k_wrap;

    // Descending scan so the lowest qualifying bit wins.
    always_comb begin
        lo_ch  = '0;
        nx_ch  = '0;
        nx_vld = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) lo_ch = CH_W'(i);
            if (mask_q[i] && i > int'(ch_q)) begin
                nx_ch  = CH_W'(i);
                nx_vld = 1'b1;
            end
        end
    end

    assign st_adv = nx_vld ? S_LOAD : S_DONE;
    assign ch_adv = nx_vld ? nx_ch : ch_q;
    assign n_wrap = (n_q == last_q);
    assign k_wrap = (k_q == last_q);

    always_comb begin
        st_d   = st_q;
        n_d    = n_q;
        k_d    = k_q;
        ch_d   = ch_q;
        dr_d   = dr_q;
        accept = 1'b0;
        reject = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (start) begin
                    if (sample_num > N_W'(1) && ch_mask != '0) begin
                        accept = 1'b1;
                        st_d   = S_LOAD;
                        n_d    = '0;
                        k_d    = '0;
                        ch_d   = lo_ch;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (n_wrap) begin
                    st_d = S_CLEAR;
                    n_d  = '0;
                end else begin
                    n_d  = n_q + 1'b1;
                end
            end
            S_CLEAR: begin
                st_d = S_COMPUTE;
                n_d  = '0;
                k_d  = '0;
            end
            S_COMPUTE: begin
                if (n_wrap) begin
                    n_d = '0;
                    if (k_wrap) begin
                        k_d  = '0;
                        dr_d = '0;
                        if (PIPE_LAT == 0) begin
                            st_d = st_adv;
                            ch_d = ch_adv;
                        end else begin
                            st_d = S_DRAIN;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    n_d = n_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (dr_q == DRAIN_LAST) begin
                    st_d = st_adv;
                    ch_d = ch_adv;
                    dr_d = '0;
                end else begin
                    dr_d = dr_q + 1'b1;
                end
            end
            S_DONE: begin
                st_d = S_IDLE;
                ch_d = '0;
            end
            default: st_d = S_IDLE;
        endcase
        // Abort overrides everything decided above.
        if (abort && st_q != S_IDLE) begin
            st_d = S_IDLE;
            n_d  = '0;
            k_d  = '0;
            ch_d = '0;
            dr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            st_q   <= S_IDLE;
            n_q    <= '0;
            k_q    <= '0;
            last_q <= '0;
            ch_q   <= '0;
            mask_q <= '0;
            inv_q  <= 1'b0;
            dr_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= ce & reject;
            if (ce) begin
                st_q <= st_d;
                n_q  <= n_d;
                k_q  <= k_d;
                ch_q <= ch_d;
                dr_q <= dr_d;
                if (accept) begin
                    last_q <= sample_num - N_W'(1);
                    mask_q <= ch_mask;
                    inv_q  <= inverse;
                end
            end
        end
    end

    // Strobes are qualified by ce so each lasts exactly one enabled cycle.
    assign busy          = (st_q != S_IDLE);
    assign load_to_cache = (st_q == S_LOAD);
    assign mac_en        = (st_q == S_COMPUTE) && !abort;
    assign clear         = ce && !abort && (st_q == S_CLEAR);
    assign bin_done      = ce && !abort && (st_q == S_COMPUTE) && n_wrap;
    assign done          = ce && !abort && (st_q == S_DONE);
    assign err           = err_q;
    assign n_idx         = n_q;
    assign k_idx         = k_q;
    assign ch_sel        = ch_q;
    assign inv_out       = inv_q;
    assign state         = st_q;

endmodule
